// File: rtl/piradip_ram_stream_reader.sv
// -----------------------------------------------------------------------------
// piradip_ram_stream_reader
//
// Reads a contiguous block of words from one port of a dual-port RAM and
// presents them as an AXI-Stream master. The block drives the client side of
// the RAM port. A credit-limited read pipeline feeds a small show-ahead skid
// FIFO, so m_tready may drop on any cycle without losing or duplicating data.
//
// Ports
//   clk, rst        single clock; asynchronous active-high reset
//   start           one-cycle request, honoured only in IDLE with count != 0
//   start_addr      first word address, sampled with start
//   count           number of words (1 .. 2^ADDR_WIDTH), sampled with start
//   busy            transfer in progress
//   done            one-cycle pulse after the last word is accepted
//   ram_en/ram_we   RAM enable / write enable (write enable tied low)
//   ram_addr        RAM read address
//   ram_wdata       RAM write data (tied low)
//   ram_rdata       RAM read data, valid READ_LATENCY cycles after ram_en
//   m_tdata/m_tvalid/m_tready/m_tlast   AXI-Stream master
//   dbg_state       current FSM state (IDLE=0, ISSUE=1, DRAIN=2)
//
// Handshake: a beat transfers on every cycle where m_tvalid and m_tready are
// both high. Once m_tvalid is raised it stays high, and m_tdata/m_tlast stay
// unchanged, until that beat transfers; m_tvalid never depends on m_tready.
// -----------------------------------------------------------------------------
module piradip_ram_stream_reader #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 10,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  input  logic [ADDR_WIDTH:0]   count,
  output logic                  busy,
  output logic                  done,
  output logic                  ram_en,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  input  logic [DATA_WIDTH-1:0] ram_rdata,
  output logic [DATA_WIDTH-1:0] m_tdata,
  output logic                  m_tvalid,
  input  logic                  m_tready,
  output logic                  m_tlast,
  output logic [1:0]            dbg_state
);

  // Two extra slots beyond the read latency keep the stream at full rate
  // while still bounding the number of words that can be outstanding.
  localparam int FIFO_DEPTH = READ_LATENCY + 2;
  localparam int PW         = $clog2(FIFO_DEPTH);
  // Wide enough to hold inflight + occupancy and FIFO_DEPTH + 1 unsigned.
  localparam int CW         = $clog2(FIFO_DEPTH + 1) + 1;
  localparam int LW         = ADDR_WIDTH + 1;

  localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);
  localparam logic [PW-1:0] LAST_SLOT = PW'(FIFO_DEPTH - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  // Control state
  logic [1:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LW-1:0]         left_q, left_d;      // reads still to issue
  logic                  done_q, done_d;

  // In-flight read tracking: bit i set means a read issued i+1 cycles ago.
  logic [READ_LATENCY-1:0] pipe_vld_q, pipe_vld_d;
  logic [READ_LATENCY-1:0] pipe_last_q, pipe_last_d;

  // Skid FIFO
  logic [DATA_WIDTH-1:0] fifo_data_q [FIFO_DEPTH];
  logic                  fifo_last_q [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         occ_q, occ_d;

  // Datapath helpers
  logic [CW-1:0] inflight;
  logic          fifo_push;
  logic          fifo_pop;
  logic          can_issue;
  logic          issue_last;
  logic          head_last;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_SLOT) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    inflight = '0;
    for (int i = 0; i < READ_LATENCY; i++) begin
      inflight = inflight + CW'(pipe_vld_q[i]);
    end
  end

  assign m_tvalid  = (occ_q != '0);
  assign head_last = fifo_last_q[rd_ptr_q];
  assign fifo_pop  = m_tvalid & m_tready;
  assign fifo_push = pipe_vld_q[READ_LATENCY-1];

  // Credit check: every word already issued or buffered owns a FIFO slot,
  // and a word leaving this cycle frees its slot for a new read right away.
  assign can_issue  = (state_q == ST_ISSUE) && (left_q != '0) &&
                      ((inflight + occ_q) < (DEPTH_C + CW'(fifo_pop)));
  assign issue_last = can_issue && (left_q == LW'(1));

  // Next-state logic
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    left_d  = left_q;
    done_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start && (count != '0)) begin
          state_d = ST_ISSUE;
          addr_d  = start_addr;
          left_d  = count;
        end
      end
      ST_ISSUE: begin
        if (can_issue) begin
          // Address wraps naturally at 2^ADDR_WIDTH.
          addr_d = addr_q + ADDR_WIDTH'(1);
          left_d = left_q - LW'(1);
          if (issue_last) begin
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (fifo_pop && head_last) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    pipe_vld_d     = pipe_vld_q;
    pipe_last_d    = pipe_last_q;
    pipe_vld_d[0]  = can_issue;
    pipe_last_d[0] = issue_last;
    for (int i = 1; i < READ_LATENCY; i++) begin
      pipe_vld_d[i]  = pipe_vld_q[i-1];
      pipe_last_d[i] = pipe_last_q[i-1];
    end
  end

  always_comb begin
    wr_ptr_d = fifo_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = fifo_pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    occ_d    = occ_q + CW'(fifo_push) - CW'(fifo_pop);
  end

  // State registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      left_q      <= '0;
      done_q      <= 1'b0;
      pipe_vld_q  <= '0;
      pipe_last_q <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      occ_q       <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      left_q      <= left_d;
      done_q      <= done_d;
      pipe_vld_q  <= pipe_vld_d;
      pipe_last_q <= pipe_last_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      occ_q       <= occ_d;
    end
  end

  // FIFO storage; the pipeline tail is exactly aligned with ram_rdata.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_data_q[i] <= '0;
        fifo_last_q[i] <= 1'b0;
      end
    end else if (fifo_push) begin
      fifo_data_q[wr_ptr_q] <= ram_rdata;
      fifo_last_q[wr_ptr_q] <= pipe_last_q[READ_LATENCY-1];
    end
  end

  // Outputs
  assign busy      = (state_q != ST_IDLE);
  assign done      = done_q;
  assign ram_en    = can_issue;
  assign ram_we    = 1'b0;
  assign ram_addr  = addr_q;
  assign ram_wdata = '0;
  // Gated so the bus reads zero whenever no beat is offered.
  assign m_tdata   = m_tvalid ? fifo_data_q[rd_ptr_q] : '0;
  assign m_tlast   = m_tvalid & head_last;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_piradip_ram_stream_reader.sv
// -----------------------------------------------------------------------------
// Testbench for piradip_ram_stream_reader. Two instances (read latency 1 and
// 3) share clock, reset and stimulus; each has its own RAM model holding
// RAM[i] = i and its own monitor/scoreboard.
// -----------------------------------------------------------------------------
module tb_piradip_ram_stream_reader;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- shared stimulus ----------------
  logic        start      = 1'b0;
  logic [9:0]  start_addr = '0;
  logic [10:0] count      = '0;
  logic        tready     = 1'b0;
  int          tag        = 0;
  int          start_cyc  = 0;

  // ---------------- DUT A (READ_LATENCY = 1) ----------------
  logic        a_busy, a_done, a_ram_en, a_ram_we, a_tvalid, a_tlast;
  logic [9:0]  a_ram_addr;
  logic [31:0] a_ram_wdata, a_ram_rdata, a_tdata;
  logic [1:0]  a_state;
  logic [31:0] a_p0 = '0;

  piradip_ram_stream_reader #(.DATA_WIDTH(32), .ADDR_WIDTH(10), .READ_LATENCY(1)) u_a (
    .clk(clk), .rst(rst), .start(start), .start_addr(start_addr), .count(count),
    .busy(a_busy), .done(a_done), .ram_en(a_ram_en), .ram_we(a_ram_we),
    .ram_addr(a_ram_addr), .ram_wdata(a_ram_wdata), .ram_rdata(a_ram_rdata),
    .m_tdata(a_tdata), .m_tvalid(a_tvalid), .m_tready(tready), .m_tlast(a_tlast),
    .dbg_state(a_state)
  );

  always @(posedge clk) if (a_ram_en) a_p0 <= {22'b0, a_ram_addr};
  assign a_ram_rdata = a_p0;

  // ---------------- DUT B (READ_LATENCY = 3) ----------------
  logic        b_busy, b_done, b_ram_en, b_ram_we, b_tvalid, b_tlast;
  logic [9:0]  b_ram_addr;
  logic [31:0] b_ram_wdata, b_ram_rdata, b_tdata;
  logic [1:0]  b_state;
  logic [31:0] b_p0 = '0, b_p1 = '0, b_p2 = '0;

  piradip_ram_stream_reader #(.DATA_WIDTH(32), .ADDR_WIDTH(10), .READ_LATENCY(3)) u_b (
    .clk(clk), .rst(rst), .start(start), .start_addr(start_addr), .count(count),
    .busy(b_busy), .done(b_done), .ram_en(b_ram_en), .ram_we(b_ram_we),
    .ram_addr(b_ram_addr), .ram_wdata(b_ram_wdata), .ram_rdata(b_ram_rdata),
    .m_tdata(b_tdata), .m_tvalid(b_tvalid), .m_tready(tready), .m_tlast(b_tlast),
    .dbg_state(b_state)
  );

  always @(posedge clk) begin
    if (b_ram_en) b_p0 <= {22'b0, b_ram_addr};
    b_p1 <= b_p0;
    b_p2 <= b_p1;
  end
  assign b_ram_rdata = b_p2;

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_bad = 0;

  // Expected beats: {tlast, tdata}; expected issue addresses.
  logic [32:0] exp_qa[$];
  logic [32:0] exp_qb[$];
  logic [9:0]  exp_addr_a[$];
  logic [9:0]  exp_addr_b[$];

  function automatic void check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, exp, $time);
    end
  endfunction

  // ---------------- monitor A ----------------
  int a_tag_seen = -1, a_out = 0, a_beats = 0, a_lasts = 0, a_dones = 0;
  int a_first_pop = -1, a_last_pop = -1, a_first_en = -1, a_last_en = -1, a_done_cyc = -1;
  logic [31:0] a_last_data = '0, a_hold_data = '0;
  logic        a_hold = 1'b0;
  logic [32:0] a_e;

  always @(negedge clk) begin
    if (rst) begin
      a_out  = 0;
      a_hold = 1'b0;
    end else begin
      if (a_tag_seen != tag) begin
        a_tag_seen = tag; a_beats = 0; a_lasts = 0; a_dones = 0;
        a_first_pop = -1; a_first_en = -1;
      end
      if (a_hold) begin
        check("a_hold_valid", a_tvalid, 1);
        check("a_hold_data", a_tdata, a_hold_data);
      end
      if (a_tvalid) check("a_valid_needs_busy", a_busy, 1);
      if (a_ram_en) begin
        if (exp_addr_a.size() == 0) check("a_unexpected_issue", a_ram_en, 0);
        else check("a_ram_addr", a_ram_addr, exp_addr_a.pop_front());
        check("a_ram_we_wdata", {a_ram_we, a_ram_wdata}, 0);
        if (a_first_en < 0) a_first_en = cyc;
        a_last_en = cyc;
      end
      if (a_tvalid && tready) begin
        if (exp_qa.size() == 0) check("a_unexpected_beat", a_tdata, 64'hdead);
        else begin
          a_e = exp_qa.pop_front();
          check("a_tdata", a_tdata, a_e[31:0]);
          check("a_tlast", a_tlast, a_e[32]);
        end
        a_beats++;
        if (a_first_pop < 0) a_first_pop = cyc;
        a_last_pop = cyc;
        if (a_tlast) begin a_lasts++; a_last_data = a_tdata; end
      end
      if (a_done) begin
        a_dones++;
        a_done_cyc = cyc;
        check("a_busy_in_done", a_busy, 0);
      end
      a_out = a_out + int'(a_ram_en) - int'(a_tvalid && tready);
      if (a_ram_en) check("a_outstanding_le_3", a_out <= 3, 1);
      a_hold      = a_tvalid && !tready;
      a_hold_data = a_tdata;
    end
  end

  // ---------------- monitor B ----------------
  int b_tag_seen = -1, b_out = 0, b_beats = 0, b_lasts = 0, b_dones = 0;
  int b_first_pop = -1, b_last_pop = -1, b_first_en = -1, b_last_en = -1, b_done_cyc = -1;
  logic [31:0] b_last_data = '0, b_hold_data = '0;
  logic        b_hold = 1'b0;
  logic [32:0] b_e;

  always @(negedge clk) begin
    if (rst) begin
      b_out  = 0;
      b_hold = 1'b0;
    end else begin
      if (b_tag_seen != tag) begin
        b_tag_seen = tag; b_beats = 0; b_lasts = 0; b_dones = 0;
        b_first_pop = -1; b_first_en = -1;
      end
      if (b_hold) begin
        check("b_hold_valid", b_tvalid, 1);
        check("b_hold_data", b_tdata, b_hold_data);
      end
      if (b_tvalid) check("b_valid_needs_busy", b_busy, 1);
      if (b_ram_en) begin
        if (exp_addr_b.size() == 0) check("b_unexpected_issue", b_ram_en, 0);
        else check("b_ram_addr", b_ram_addr, exp_addr_b.pop_front());
        check("b_ram_we_wdata", {b_ram_we, b_ram_wdata}, 0);
        if (b_first_en < 0) b_first_en = cyc;
        b_last_en = cyc;
      end
      if (b_tvalid && tready) begin
        if (exp_qb.size() == 0) check("b_unexpected_beat", b_tdata, 64'hdead);
        else begin
          b_e = exp_qb.pop_front();
          check("b_tdata", b_tdata, b_e[31:0]);
          check("b_tlast", b_tlast, b_e[32]);
        end
        b_beats++;
        if (b_first_pop < 0) b_first_pop = cyc;
        b_last_pop = cyc;
        if (b_tlast) begin b_lasts++; b_last_data = b_tdata; end
      end
      if (b_done) begin
        b_dones++;
        b_done_cyc = cyc;
        check("b_busy_in_done", b_busy, 0);
      end
      b_out = b_out + int'(b_ram_en) - int'(b_tvalid && tready);
      if (b_ram_en) check("b_outstanding_le_5", b_out <= 5, 1);
      b_hold      = b_tvalid && !tready;
      b_hold_data = b_tdata;
    end
  end

  // ---------------- driver tasks ----------------
  // Inputs change 2 time units after each rising edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  function automatic logic ready_for(input int mode);
    case (mode)
      0:       return 1'b1;
      1:       return (cyc % 4 == 0) || (cyc % 4 == 3);   // 1,0,0,1
      default: return 1'($urandom_range(0, 1));
    endcase
  endfunction

  task automatic push_xfer(input logic [9:0] sa, input int n, input bit to_a, input bit to_b);
    for (int i = 0; i < n; i++) begin
      logic [9:0] ad;
      ad = sa + 10'(i);
      if (to_a) begin exp_qa.push_back({(i == n - 1), 22'b0, ad}); exp_addr_a.push_back(ad); end
      if (to_b) begin exp_qb.push_back({(i == n - 1), 22'b0, ad}); exp_addr_b.push_back(ad); end
    end
  endtask

  task automatic launch(input logic [9:0] sa, input int n);
    start      = 1'b1;
    start_addr = sa;
    count      = 11'(n);
    start_cyc  = cyc;
    tick();
    start      = 1'b0;
  endtask

  task automatic wait_dones(input int na, input int nb, input int mode, input int budget);
    int k;
    k = 0;
    while ((a_dones < na || b_dones < nb) && k < budget) begin
      tready = ready_for(mode);
      tick();
      k++;
    end
    check("wait_within_budget", k < budget, 1);
    tready = 1'b1;
    repeat (4) tick();
  endtask

  task automatic clear_queues();
    exp_qa.delete(); exp_qb.delete(); exp_addr_a.delete(); exp_addr_b.delete();
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [9:0]  sa;
    int          n;
    int          mode;      // 0 always ready, 1 pattern 1,0,0,1, 2 random
    logic [31:0] exp_last;  // data of the tlast word (RAM[i] = i)
  } vec_t;

  vec_t vecs [8];

  initial begin
    vecs[0] = '{10'h010,    4, 0, 32'h013};
    vecs[1] = '{10'h100,    8, 1, 32'h107};
    vecs[2] = '{10'h3FE,    4, 0, 32'h001};
    vecs[3] = '{10'h200,    1, 1, 32'h200};
    vecs[4] = '{10'h000, 1024, 0, 32'h3FF};
    vecs[5] = '{10'h123,   20, 2, 32'h136};
    vecs[6] = '{10'h3F0,   32, 2, 32'h00F};
    vecs[7] = '{10'h3FF,    5, 1, 32'h003};

    // ---- reset values ----
    rst = 1'b1;
    tick();
    tick();
    check("rst_a_busy",   a_busy, 0);     check("rst_b_busy",   b_busy, 0);
    check("rst_a_done",   a_done, 0);     check("rst_b_done",   b_done, 0);
    check("rst_a_ram_en", a_ram_en, 0);   check("rst_b_ram_en", b_ram_en, 0);
    check("rst_a_addr",   a_ram_addr, 0); check("rst_b_addr",   b_ram_addr, 0);
    check("rst_a_tvalid", a_tvalid, 0);   check("rst_b_tvalid", b_tvalid, 0);
    check("rst_a_tlast",  a_tlast, 0);    check("rst_b_tlast",  b_tlast, 0);
    check("rst_a_tdata",  a_tdata, 0);    check("rst_b_tdata",  b_tdata, 0);
    check("rst_a_state",  a_state, 0);    check("rst_b_state",  b_state, 0);
    rst = 1'b0;
    tick();

    // ---- table-driven transfers ----
    for (int v = 0; v < 8; v++) begin
      tag++;
      tready = ready_for(vecs[v].mode);
      push_xfer(vecs[v].sa, vecs[v].n, 1'b1, 1'b1);
      launch(vecs[v].sa, vecs[v].n);
      wait_dones(1, 1, vecs[v].mode, vecs[v].n * 6 + 60);
      check($sformatf("v%0d_a_dones", v), a_dones, 1);
      check($sformatf("v%0d_b_dones", v), b_dones, 1);
      check($sformatf("v%0d_a_beats", v), a_beats, vecs[v].n);
      check($sformatf("v%0d_b_beats", v), b_beats, vecs[v].n);
      check($sformatf("v%0d_a_lasts", v), a_lasts, 1);
      check($sformatf("v%0d_b_lasts", v), b_lasts, 1);
      check($sformatf("v%0d_a_last_data", v), a_last_data, vecs[v].exp_last);
      check($sformatf("v%0d_b_last_data", v), b_last_data, vecs[v].exp_last);
      check($sformatf("v%0d_a_left", v), exp_qa.size() + exp_addr_a.size(), 0);
      check($sformatf("v%0d_b_left", v), exp_qb.size() + exp_addr_b.size(), 0);
      check($sformatf("v%0d_a_done_cyc", v), a_done_cyc, a_last_pop + 1);
      check($sformatf("v%0d_b_done_cyc", v), b_done_cyc, b_last_pop + 1);
      if (vecs[v].mode == 0) begin
        check($sformatf("v%0d_a_first_en", v), a_first_en - start_cyc, 1);
        check($sformatf("v%0d_b_first_en", v), b_first_en - start_cyc, 1);
        check($sformatf("v%0d_a_first_valid", v), a_first_pop - start_cyc, 3);
        check($sformatf("v%0d_b_first_valid", v), b_first_pop - start_cyc, 5);
        check($sformatf("v%0d_a_en_span", v), a_last_en - a_first_en, vecs[v].n - 1);
        check($sformatf("v%0d_b_en_span", v), b_last_en - b_first_en, vecs[v].n - 1);
        check($sformatf("v%0d_a_beat_span", v), a_last_pop - a_first_pop, vecs[v].n - 1);
        check($sformatf("v%0d_b_beat_span", v), b_last_pop - b_first_pop, vecs[v].n - 1);
      end
    end

    // ---- count = 0 is ignored ----
    tag++;
    tready = 1'b1;
    launch(10'h040, 0);
    for (int i = 0; i < 6; i++) begin
      check("cnt0_a_busy", a_busy, 0);
      check("cnt0_b_busy", b_busy, 0);
      tick();
    end
    check("cnt0_a_dones", a_dones, 0);
    check("cnt0_b_dones", b_dones, 0);

    // ---- start while busy is ignored ----
    tag++;
    push_xfer(10'h050, 6, 1'b1, 1'b1);
    launch(10'h050, 6);
    tick();
    tick();
    launch(10'h300, 5);
    wait_dones(1, 1, 0, 100);
    check("busy_start_a_dones", a_dones, 1);
    check("busy_start_b_dones", b_dones, 1);
    check("busy_start_a_last", a_last_data, 32'h055);
    check("busy_start_b_last", b_last_data, 32'h055);
    check("busy_start_left", exp_qa.size() + exp_qb.size() + exp_addr_a.size() + exp_addr_b.size(), 0);

    // ---- new start accepted in the done cycle (A restarts, B still busy) ----
    tag++;
    push_xfer(10'h060, 3, 1'b1, 1'b1);
    launch(10'h060, 3);
    begin
      int k;
      k = 0;
      while (!a_done && k < 50) begin tick(); k++; end
      check("restart_wait_done", k < 50, 1);
    end
    push_xfer(10'h070, 2, 1'b1, 1'b0);
    launch(10'h070, 2);
    wait_dones(2, 1, 0, 100);
    check("restart_a_dones", a_dones, 2);
    check("restart_b_dones", b_dones, 1);
    check("restart_a_beats", a_beats, 5);
    check("restart_b_beats", b_beats, 3);
    check("restart_a_last", a_last_data, 32'h071);
    check("restart_left", exp_qa.size() + exp_qb.size() + exp_addr_a.size() + exp_addr_b.size(), 0);

    // ---- reset in the middle of a stalled transfer ----
    tag++;
    tready = 1'b0;
    push_xfer(10'h080, 16, 1'b1, 1'b1);
    launch(10'h080, 16);
    repeat (12) tick();
    check("stall_a_outstanding", a_out, 3);
    check("stall_b_outstanding", b_out, 5);
    check("stall_a_tvalid", a_tvalid, 1);
    check("stall_b_tvalid", b_tvalid, 1);
    check("stall_a_ram_en", a_ram_en, 0);
    check("stall_a_state", a_state, 1);
    rst = 1'b1;
    #1;
    check("midrst_a_tvalid", a_tvalid, 0); check("midrst_b_tvalid", b_tvalid, 0);
    check("midrst_a_busy",   a_busy, 0);   check("midrst_b_busy",   b_busy, 0);
    check("midrst_a_ram_en", a_ram_en, 0); check("midrst_b_ram_en", b_ram_en, 0);
    clear_queues();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("postrst_a_done", a_done, 0);
      check("postrst_b_done", b_done, 0);
      tick();
    end
    tag++;
    tready = 1'b1;
    push_xfer(10'h0A0, 2, 1'b1, 1'b1);
    launch(10'h0A0, 2);
    wait_dones(1, 1, 0, 60);
    check("postrst_a_beats", a_beats, 2);
    check("postrst_b_beats", b_beats, 2);
    check("postrst_a_dones", a_dones, 1);
    check("postrst_b_dones", b_dones, 1);
    check("postrst_a_last", a_last_data, 32'h0A1);
    check("postrst_b_last", b_last_data, 32'h0A1);
    check("postrst_left", exp_qa.size() + exp_qb.size() + exp_addr_a.size() + exp_addr_b.size(), 0);

    // ---- report ----
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Global time limit.
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at t=%0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/piradip_ram_stream_reader.md
Name: piradip_ram_stream_reader

Overview:
RAM client that reads a contiguous block of words from one port of a dual-port RAM and emits them as an AXI-Stream master with backpressure. It drives the CLIENT side of the RAM port signals: en, we, addr and wdata out; rdata in. A start pulse launches a transfer of a programmable length from a programmable start address. A credit-limited read pipeline plus a small skid FIFO absorbs the RAM read latency, so that m_tready can stall at any cycle without losing data.

Parameters:
DATA_WIDTH, 32, RAM word width and stream tdata width.
ADDR_WIDTH, 10, RAM address width; the RAM holds 2^ADDR_WIDTH words.
READ_LATENCY, 1, cycles from ram_en to valid ram_rdata; legal range 1..4; must match the RAM instance.

Ports:
clk  in  1  single clock for the RAM port and the stream.
rst  in  1  asynchronous active-high reset; one clock; reset is asynchronous and active-high.
start  in  1  one-cycle request; sampled only in IDLE.
start_addr  in  ADDR_WIDTH  first word address; sampled with start.
count  in  ADDR_WIDTH+1  number of words, 1..2^ADDR_WIDTH; sampled with start.
busy  out  1  transfer in progress.
done  out  1  one-cycle pulse when a transfer completes.
ram_en  out  1  RAM port enable.
ram_we  out  1  RAM write enable; constant 0.
ram_addr  out  ADDR_WIDTH  RAM read address.
ram_wdata  out  DATA_WIDTH  RAM write data; constant 0.
ram_rdata  in  DATA_WIDTH  RAM read data.
m_tdata  out  DATA_WIDTH  stream data.
m_tvalid  out  1  stream valid.
m_tready  in  1  stream ready.
m_tlast  out  1  asserted on the final word of a transfer.

Behaviour:
- Reset values: busy=0, done=0, ram_en=0, ram_addr=0, m_tvalid=0, m_tlast=0, m_tdata=0. The FIFO, the in-flight pipeline and all counters are cleared.
- FSM states: IDLE, ISSUE, DRAIN.
  - IDLE -> ISSUE on start=1 with count!=0. The block latches start_addr and count, and busy=1 from the next cycle.
  - start with count=0 is ignored: no busy, no done.
  - start outside IDLE is ignored.
- ISSUE:
  - Issue rule: a read is issued (ram_en=1, ram_addr=current address) when words_remaining_to_issue>0 and (inflight + fifo_occupancy - pop_this_cycle) < FIFO_DEPTH.
  - FIFO_DEPTH is a localparam equal to READ_LATENCY+2.
  - After each issue the address increments modulo 2^ADDR_WIDTH (wrap 2^ADDR_WIDTH-1 -> 0).
  - ISSUE -> DRAIN when the last read is issued.
- In-flight tracking: a READ_LATENCY-deep valid/last shift register. ram_rdata is written into the FIFO exactly READ_LATENCY cycles after its ram_en. The last flag accompanies the final word.
- Stream output:
  - The FIFO is show-ahead. m_tvalid = FIFO not empty; m_tdata/m_tlast come from the FIFO head.
  - A pop occurs on m_tvalid & m_tready.
  - m_tdata is stable while m_tvalid=1 and m_tready=0.
  - m_tvalid is never asserted in IDLE.
- Throughput: with m_tready held at 1, one word per cycle after the initial latency. The first m_tvalid is at cycle 1+READ_LATENCY after the first ram_en, since the FIFO write takes one cycle.
- DRAIN -> IDLE on the handshake of the m_tlast word. done=1 for exactly the following cycle, with busy=0 in that same cycle. A new start is accepted in that done cycle.
- Overflow: never occurs. The issue rule guarantees FIFO occupancy ≤ FIFO_DEPTH under any m_tready pattern. Underflow is impossible because pop requires m_tvalid.
- count=2^ADDR_WIDTH reads the entire RAM once, starting at start_addr and wrapping.
- Reset mid-transfer clears everything immediately. No done pulse is generated. Data from in-flight reads arriving after reset is discarded.

Test Plan:
- L=1, start_addr=0x010, count=4, RAM[i]=i, tready=1 -> ram_en for 4 consecutive cycles (addr 0x010..0x013); tdata 0x10,0x11,0x12,0x13 on consecutive cycles; tlast on 0x13; done one cycle after.
- L=3, count=8, tready toggling 1,0,0,1 pattern -> all 8 words in order, no duplicates or drops; occupancy never exceeds 5; tdata held stable during stalls.
- start_addr=0x3FE, count=4, ADDR_WIDTH=10 -> addresses 0x3FE,0x3FF,0x000,0x001; tlast on the word from 0x001.
- count=0 start, and start while busy -> no busy/done change; the active transfer is unaffected.
- count=1024 with tready=1 -> 1024 beats in 1024 consecutive cycles after the first valid; exactly one tlast; exactly one done.
- Assert rst mid-transfer (tready=0, FIFO full) -> the same cycle shows m_tvalid=0, busy=0, ram_en=0; no done pulse; the next start with count=2 produces exactly 2 correct beats.
